// File: rtl/pe_array_ctrl_pkg.sv
// rtl/pe_array_ctrl_pkg.sv - shared types and field offsets for the PE array controller
// Contents: FSM state enum, GLB source index enum, scan word field indices,
// PE_config bit offset within the CFG word, counter widths.
package pe_array_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN_Y = 3'd1,
        SCAN_X = 3'd2,
        CFG    = 3'd3,
        LOAD   = 3'd4,
        RUN    = 3'd5,
        DONE   = 3'd6
    } state_e;

    // Source index doubles as the bit position in the arbiter's one-hot vectors.
    typedef enum logic [1:0] {
        SRC_F = 2'd0,
        SRC_I = 2'd1,
        SRC_P = 2'd2
    } src_e;

    // Scan words carry four ID fields; field k sits at bits [k*W +: W].
    localparam int SCAN_IFMAP_IDX  = 0;
    localparam int SCAN_FILTER_IDX = 1;
    localparam int SCAN_IPSUM_IDX  = 2;
    localparam int SCAN_OPSUM_IDX  = 3;

    localparam int PE_CFG_OFFSET   = 16;

    localparam int SCAN_CNT_BITS   = 9;
    localparam int OPSUM_CNT_BITS  = 16;

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - 3-way rotating-priority arbiter with grant lock
// Ports:
//   clk, rst   clock, async active-high reset
//   en         arbitration enabled; when low no grant is issued and the lock clears
//   valid[2:0] request per source (index = src_e)
//   hs_done    the granted transfer completed this cycle
//   grant[2:0] one-hot grant
module rr_arb3
    import pe_array_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] valid,
    input  logic       hs_done,
    output logic [2:0] grant
);

    src_e       ptr_q, ptr_d;
    logic       lock_q, lock_d;
    logic [2:0] lock_grant_q, lock_grant_d;
    logic [2:0] pri_grant;

    // First valid source at or after the pointer, in filter->ifmap->ipsum order.
    always_comb begin
        pri_grant = 3'b000;
        case (ptr_q)
            SRC_I:   pri_grant = valid[1] ? 3'b010 : valid[2] ? 3'b100 : valid[0] ? 3'b001 : 3'b000;
            SRC_P:   pri_grant = valid[2] ? 3'b100 : valid[0] ? 3'b001 : valid[1] ? 3'b010 : 3'b000;
            default: pri_grant = valid[0] ? 3'b001 : valid[1] ? 3'b010 : valid[2] ? 3'b100 : 3'b000;
        endcase
    end

    // A stalled grant is pinned so the array never sees the data switch mid-handshake.
    always_comb begin
        grant = 3'b000;
        if (en) begin
            grant = lock_q ? lock_grant_q : pri_grant;
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        lock_d       = lock_q;
        lock_grant_d = lock_grant_q;
        if (!en) begin
            lock_d       = 1'b0;
            lock_grant_d = 3'b000;
        end else if (hs_done) begin
            lock_d       = 1'b0;
            lock_grant_d = 3'b000;
            case (grant)
                3'b001:  ptr_d = SRC_I;
                3'b010:  ptr_d = SRC_P;
                default: ptr_d = SRC_F;
            endcase
        end else if (grant != 3'b000) begin
            lock_d       = 1'b1;
            lock_grant_d = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= SRC_F;
            lock_q       <= 1'b0;
            lock_grant_q <= 3'b000;
        end else begin
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
        end
    end

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - PE array layer sequencer and GLB port arbiter
// Ports:
//   clk, rst                         clock, async active-high reset
//   start, opsum_total               layer start (IDLE only) and expected opsum count
//   busy, done                       not-IDLE status, one-cycle layer-end pulse
//   cfg_valid/cfg_ready/cfg_data     configuration word stream (Y scan, X scan, CFG)
//   set_XID, set_YID, set_LN         one-cycle load strobes to the array
//   *_XID_scan_in, *_YID_scan_in     registered scan chain data
//   LN_config_in, PE_config, PE_en   array configuration and enables
//   src_{f,i,p}_*                    GLB source handshakes
//   GLB_{filter,ifmap,ipsum}_*       array-side handshakes, shared GLB_data_in bus
//   GLB_opsum_valid/ready            observed opsum transfers
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int XID_BITS    = 5,
    parameter int YID_BITS    = 3,
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [15:0]                        opsum_total,
    output logic                               busy,
    output logic                               done,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [DATA_BITS-1:0]               cfg_data,
    output logic                               set_XID,
    output logic                               set_YID,
    output logic                               set_LN,
    output logic [XID_BITS-1:0]                ifmap_XID_scan_in,
    output logic [XID_BITS-1:0]                filter_XID_scan_in,
    output logic [XID_BITS-1:0]                ipsum_XID_scan_in,
    output logic [XID_BITS-1:0]                opsum_XID_scan_in,
    output logic [YID_BITS-1:0]                ifmap_YID_scan_in,
    output logic [YID_BITS-1:0]                filter_YID_scan_in,
    output logic [YID_BITS-1:0]                ipsum_YID_scan_in,
    output logic [YID_BITS-1:0]                opsum_YID_scan_in,
    output logic [NUMS_PE_ROW-2:0]             LN_config_in,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_en,
    output logic [CONFIG_SIZE-1:0]             PE_config,
    input  logic                               src_f_valid,
    output logic                               src_f_ready,
    input  logic [DATA_BITS-1:0]               src_f_data,
    input  logic                               src_i_valid,
    output logic                               src_i_ready,
    input  logic [DATA_BITS-1:0]               src_i_data,
    input  logic                               src_p_valid,
    output logic                               src_p_ready,
    input  logic [DATA_BITS-1:0]               src_p_data,
    output logic                               GLB_filter_valid,
    input  logic                               GLB_filter_ready,
    output logic                               GLB_ifmap_valid,
    input  logic                               GLB_ifmap_ready,
    output logic                               GLB_ipsum_valid,
    input  logic                               GLB_ipsum_ready,
    output logic [DATA_BITS-1:0]               GLB_data_in,
    input  logic                               GLB_opsum_valid,
    input  logic                               GLB_opsum_ready
);

    localparam int YW = 4 * YID_BITS;
    localparam int XW = 4 * XID_BITS;
    localparam logic [SCAN_CNT_BITS-1:0] Y_LAST = SCAN_CNT_BITS'(NUMS_PE_ROW - 1);
    localparam logic [SCAN_CNT_BITS-1:0] X_LAST = SCAN_CNT_BITS'(NUMS_PE_ROW * NUMS_PE_COL - 1);

    state_e                      state_q, state_d;
    logic [SCAN_CNT_BITS-1:0]    scan_cnt_q, scan_cnt_d;
    logic [OPSUM_CNT_BITS-1:0]   opsum_cnt_q, opsum_cnt_d;
    logic [OPSUM_CNT_BITS-1:0]   opsum_total_q, opsum_total_d;
    logic                        set_yid_q, set_yid_d;
    logic                        set_xid_q, set_xid_d;
    logic                        set_ln_q, set_ln_d;
    logic [YW-1:0]               y_fields_q, y_fields_d;
    logic [XW-1:0]               x_fields_q, x_fields_d;
    logic [NUMS_PE_ROW-2:0]      ln_cfg_q, ln_cfg_d;
    logic [CONFIG_SIZE-1:0]      pe_cfg_q, pe_cfg_d;

    logic       cfg_fire;
    logic       opsum_fire;
    logic       opsum_last;
    logic       arb_en;
    logic       arb_hs;
    logic [2:0] src_valid;
    logic [2:0] glb_ready;
    logic [2:0] grant;
    logic       unused_cfg_bits;

    assign cfg_fire   = cfg_valid & cfg_ready;
    assign opsum_fire = GLB_opsum_valid & GLB_opsum_ready;
    assign opsum_last = (opsum_cnt_q + 16'd1) == opsum_total_q;
    assign unused_cfg_bits = ^cfg_data[DATA_BITS-1:PE_CFG_OFFSET+CONFIG_SIZE];

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN_Y;
            SCAN_Y:  if (cfg_fire && scan_cnt_q == Y_LAST) state_d = SCAN_X;
            SCAN_X:  if (cfg_fire && scan_cnt_q == X_LAST) state_d = CFG;
            CFG:     if (cfg_fire) state_d = LOAD;
            LOAD:    state_d = (opsum_total_q == '0) ? DONE : RUN;
            RUN:     if (opsum_fire && opsum_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        cfg_ready = (state_q == SCAN_Y) || (state_q == SCAN_X) || (state_q == CFG);
        PE_en     = (state_q == LOAD) ? '1 : '0;
        arb_en    = (state_q == RUN);
    end

    // Counters and registered array-side configuration
    always_comb begin
        scan_cnt_d    = scan_cnt_q;
        opsum_cnt_d   = opsum_cnt_q;
        opsum_total_d = opsum_total_q;
        set_yid_d     = 1'b0;
        set_xid_d     = 1'b0;
        set_ln_d      = 1'b0;
        y_fields_d    = y_fields_q;
        x_fields_d    = x_fields_q;
        ln_cfg_d      = ln_cfg_q;
        pe_cfg_d      = pe_cfg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opsum_total_d = opsum_total;
                    scan_cnt_d    = '0;
                    opsum_cnt_d   = '0;
                end
            end
            SCAN_Y: begin
                if (cfg_fire) begin
                    set_yid_d  = 1'b1;
                    y_fields_d = cfg_data[YW-1:0];
                    scan_cnt_d = (scan_cnt_q == Y_LAST) ? '0 : scan_cnt_q + 1'b1;
                end
            end
            SCAN_X: begin
                if (cfg_fire) begin
                    set_xid_d  = 1'b1;
                    x_fields_d = cfg_data[XW-1:0];
                    scan_cnt_d = (scan_cnt_q == X_LAST) ? '0 : scan_cnt_q + 1'b1;
                end
            end
            CFG: begin
                if (cfg_fire) begin
                    set_ln_d = 1'b1;
                    ln_cfg_d = cfg_data[NUMS_PE_ROW-2:0];
                    pe_cfg_d = cfg_data[PE_CFG_OFFSET +: CONFIG_SIZE];
                end
            end
            RUN: begin
                if (opsum_fire) opsum_cnt_d = opsum_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            opsum_cnt_q   <= '0;
            opsum_total_q <= '0;
            set_yid_q     <= 1'b0;
            set_xid_q     <= 1'b0;
            set_ln_q      <= 1'b0;
            y_fields_q    <= '0;
            x_fields_q    <= '0;
            ln_cfg_q      <= '0;
            pe_cfg_q      <= '0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            opsum_cnt_q   <= opsum_cnt_d;
            opsum_total_q <= opsum_total_d;
            set_yid_q     <= set_yid_d;
            set_xid_q     <= set_xid_d;
            set_ln_q      <= set_ln_d;
            y_fields_q    <= y_fields_d;
            x_fields_q    <= x_fields_d;
            ln_cfg_q      <= ln_cfg_d;
            pe_cfg_q      <= pe_cfg_d;
        end
    end

    assign set_YID            = set_yid_q;
    assign set_XID            = set_xid_q;
    assign set_LN             = set_ln_q;
    assign ifmap_YID_scan_in  = y_fields_q[SCAN_IFMAP_IDX*YID_BITS +: YID_BITS];
    assign filter_YID_scan_in = y_fields_q[SCAN_FILTER_IDX*YID_BITS +: YID_BITS];
    assign ipsum_YID_scan_in  = y_fields_q[SCAN_IPSUM_IDX*YID_BITS +: YID_BITS];
    assign opsum_YID_scan_in  = y_fields_q[SCAN_OPSUM_IDX*YID_BITS +: YID_BITS];
    assign ifmap_XID_scan_in  = x_fields_q[SCAN_IFMAP_IDX*XID_BITS +: XID_BITS];
    assign filter_XID_scan_in = x_fields_q[SCAN_FILTER_IDX*XID_BITS +: XID_BITS];
    assign ipsum_XID_scan_in  = x_fields_q[SCAN_IPSUM_IDX*XID_BITS +: XID_BITS];
    assign opsum_XID_scan_in  = x_fields_q[SCAN_OPSUM_IDX*XID_BITS +: XID_BITS];
    assign LN_config_in       = ln_cfg_q;
    assign PE_config          = pe_cfg_q;

    // GLB input bus arbitration: purely combinational source -> array path.
    assign src_valid = {src_p_valid, src_i_valid, src_f_valid};
    assign glb_ready = {GLB_ipsum_ready, GLB_ifmap_ready, GLB_filter_ready};
    assign arb_hs    = |(grant & src_valid & glb_ready);

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en),
        .valid   (src_valid),
        .hs_done (arb_hs),
        .grant   (grant)
    );

    assign GLB_filter_valid = grant[SRC_F] & src_f_valid;
    assign GLB_ifmap_valid  = grant[SRC_I] & src_i_valid;
    assign GLB_ipsum_valid  = grant[SRC_P] & src_p_valid;
    assign src_f_ready      = grant[SRC_F] & GLB_filter_ready;
    assign src_i_ready      = grant[SRC_I] & GLB_ifmap_ready;
    assign src_p_ready      = grant[SRC_P] & GLB_ipsum_ready;

    always_comb begin
        GLB_data_in = '0;
        if (grant[SRC_F])      GLB_data_in = src_f_data;
        else if (grant[SRC_I]) GLB_data_in = src_i_data;
        else if (grant[SRC_P]) GLB_data_in = src_p_data;
    end

endmodule
